// File: rtl/sample_fifo_ctrl.sv
// Streaming FIFO controller in front of a separate-port SRAM sample buffer.
// Samples are written one cycle after acceptance and read back into a registered output stage.
module sample_fifo_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] sram_write_addr,
    output logic [DATA_WIDTH-1:0] sram_write_data,
    output logic                  sram_write_en,
    output logic [ADDR_WIDTH-1:0] sram_read_addr,
    input  logic [DATA_WIDTH-1:0] sram_read_data
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int LW = ADDR_WIDTH + 2;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         cptr_q, cptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  overflow_q, overflow_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [PW-1:0] scnt;
    logic [PW-1:0] scnt_d;
    logic          accept;
    logic          readable;
    logic          fetch;

    // in_ready looks only at registered occupancy, so a pop never frees a slot in the same cycle.
    always_comb begin
        scnt     = wptr_q - rptr_q;
        in_ready = (scnt != DEPTH) && !flush;
        accept   = in_valid && in_ready;
        readable = (cptr_q != rptr_q);
        fetch    = readable && (!out_valid_q || out_ready);
    end

    always_comb begin
        wptr_d      = wptr_q;
        cptr_d      = cptr_q;
        rptr_d      = rptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;

        if (flush) begin
            wptr_d      = '0;
            cptr_d      = '0;
            rptr_d      = '0;
            out_valid_d = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            // Commit pointer trails wptr so a read never races the SRAM write.
            cptr_d = wptr_q;
            if (accept) begin
                we_d    = 1'b1;
                waddr_d = wptr_q[ADDR_WIDTH-1:0];
                wdata_d = in_data;
                wptr_d  = wptr_q + 1'b1;
            end
            if (in_valid && !in_ready) begin
                overflow_d = 1'b1;
            end
            if (fetch) begin
                out_data_d  = sram_read_data;
                out_valid_d = 1'b1;
                rptr_d      = rptr_q + 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end

        scnt_d  = wptr_d - rptr_d;
        level_d = {1'b0, scnt_d} + {{(LW-1){1'b0}}, out_valid_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            cptr_q      <= '0;
            rptr_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            level_q     <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            cptr_q      <= cptr_d;
            rptr_q      <= rptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            level_q     <= level_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign out_data        = out_data_q;
    assign out_valid       = out_valid_q;
    assign overflow        = overflow_q;
    assign level           = level_q;
    assign sram_write_en   = we_q;
    assign sram_write_addr = waddr_q;
    assign sram_write_data = wdata_q;
    assign sram_read_addr  = rptr_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sample_fifo_ctrl.sv
// Bench for sample_fifo_ctrl: 16-deep SRAM attached, queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_sample_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW+1:0] level;
    logic          overflow;
    logic [AW-1:0] sram_write_addr;
    logic [DW-1:0] sram_write_data;
    logic          sram_write_en;
    logic [AW-1:0] sram_read_addr;
    logic [DW-1:0] sram_read_data;

    always #5 clk = ~clk;

    sample_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .level           (level),
        .overflow        (overflow),
        .sram_write_addr (sram_write_addr),
        .sram_write_data (sram_write_data),
        .sram_write_en   (sram_write_en),
        .sram_read_addr  (sram_read_addr),
        .sram_read_data  (sram_read_data)
    );

    // SRAM: synchronous write, asynchronous read
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (sram_write_en) mem[sram_write_addr] <= sram_write_data;
    assign sram_read_data = mem[sram_read_addr];

    int n_tests;
    int n_fail;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: samples held in the buffer with the cycle they were accepted.
    logic [DW-1:0] exp_q[$];
    int            exp_t[$];
    logic [DW-1:0] obs_q[$];
    logic          m_ov;
    logic [DW-1:0] m_od;
    logic          m_ovf;
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            wr_idx;
    int            rd_idx;
    int            cyc;
    bit            m_fetch;
    bit            m_room;

    initial begin
        m_ov = 0; m_od = '0; m_ovf = 0; m_we = 0; m_waddr = '0; m_wdata = '0;
        wr_idx = 0; rd_idx = 0; cyc = 0;
    end

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            exp_q.delete();
            exp_t.delete();
            m_ov   = 1'b0;
            m_ovf  = 1'b0;
            m_we   = 1'b0;
            wr_idx = 0;
            rd_idx = 0;
        end else begin
            m_room  = (exp_q.size() != DEPTH);
            // a sample becomes visible at the output two edges after acceptance
            m_fetch = (exp_q.size() > 0) && (exp_t[0] <= cyc - 2) && (!m_ov || out_ready);
            if (m_fetch) begin
                m_od = exp_q.pop_front();
                void'(exp_t.pop_front());
                m_ov = 1'b1;
                rd_idx++;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (in_valid && m_room) begin
                exp_q.push_back(in_data);
                exp_t.push_back(cyc);
                m_we    = 1'b1;
                m_waddr = AW'(wr_idx % DEPTH);
                m_wdata = in_data;
                wr_idx++;
            end else begin
                m_we = 1'b0;
            end
            if (in_valid && !m_room) m_ovf = 1'b1;
        end
        cyc++;
    end

    // Compare process: every negedge
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_level", level, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_write_en", sram_write_en, 0);
            chk("rst_write_addr", sram_write_addr, 0);
            chk("rst_write_data", sram_write_data, 0);
            chk("rst_read_addr", sram_read_addr, 0);
        end else begin
            chk("out_valid", out_valid, m_ov);
            if (m_ov) chk("out_data", out_data, m_od);
            chk("level", level, exp_q.size() + int'(m_ov));
            chk("in_ready", in_ready, (exp_q.size() != DEPTH) && !flush);
            chk("overflow", overflow, m_ovf);
            chk("write_en", sram_write_en, m_we);
            if (m_we) begin
                chk("write_addr", sram_write_addr, m_waddr);
                chk("write_data", sram_write_data, m_wdata);
            end
            chk("read_addr", sram_read_addr, rd_idx % DEPTH);
            if (out_valid && out_ready && !flush) obs_q.push_back(out_data);
        end
    end

    // Inputs change 2 time units after the active edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + DW'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_a5a5_first(input string tag);
        tick();
        obs_q.delete();
        in_valid  = 1'b1;
        in_data   = 16'hA5A5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        out_ready = 1'b0;
        chk({tag, "_obs_count"}, obs_q.size(), 1);
        if (obs_q.size() > 0) chk({tag, "_first_out"}, obs_q[0], 16'hA5A5);
    endtask

    initial begin
        int  i;
        int  guard;
        bit  acc;
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        out_ready = 1'b0;

        // reset with in_valid held high
        repeat (3) tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_level", level, 0);

        // single sample
        tick();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_write_en", sram_write_en, 1);
        chk("single_write_addr", sram_write_addr, 0);
        tick();
        tick();
        @(negedge clk);
        chk("single_out_valid", out_valid, 1);
        chk("single_out_data", out_data, 16'h1234);
        chk("single_level", level, 1);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // fill to capacity, then overflow
        push_n(17, 16'd0);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        @(negedge clk);
        chk("fill_level", level, 17);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_overflow_pre", overflow, 0);
        tick();
        @(negedge clk);
        chk("ovf_flag", overflow, 1);
        chk("ovf_no_write", sram_write_en, 0);
        tick();
        in_valid = 1'b0;

        // drain
        obs_q.delete();
        out_ready = 1'b1;
        repeat (20) tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("drain_level", level, 0);
        chk("drain_out_valid", out_valid, 0);
        chk("drain_count", obs_q.size(), 17);
        for (int k = 0; k < 17; k++)
            if (k < obs_q.size()) chk("drain_order", obs_q[k], k);

        // streaming with wrap and random back-pressure
        tick();
        obs_q.delete();
        i     = 0;
        guard = 0;
        while (i < 100 && guard < 3000) begin
            in_valid  = 1'b1;
            in_data   = DW'(i);
            out_ready = 1'($urandom_range(0, 1));
            acc       = in_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        chk("stream_accepted", i, 100);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (25) tick();
        out_ready = 1'b0;
        chk("stream_count", obs_q.size(), 100);
        for (int k = 0; k < 100; k++)
            if (k < obs_q.size()) chk("stream_order", obs_q[k], k);

        // flush mid-stream
        tick();
        push_n(9, 16'h0100);
        tick();
        tick();
        @(negedge clk);
        chk("pre_flush_level", level, 9);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_level", level, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_overflow", overflow, 0);
        check_a5a5_first("flush");

        // reset mid-stream
        tick();
        push_n(9, 16'h0200);
        tick();
        tick();
        @(negedge clk);
        chk("pre_reset_level", level, 9);
        tick();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mrst_level", level, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_overflow", overflow, 0);
        chk("mrst_in_ready", in_ready, 1);
        check_a5a5_first("mrst");

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
